// File: rtl/fft_power_collector.sv
// Collects 16 complex FFT bins per frame, computes re^2+im^2 per bin, and presents the
// frame's powers in parallel with a one-cycle fft_valid. Optional macro FFT_PWR_PIPE_EN.
module fft_power_collector #(
    parameter int unsigned NBIN = 16,
    parameter int unsigned DW   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_first,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    output logic                 fft_valid,
    output logic [2*DW-1:0]      fft_d0,
    output logic [2*DW-1:0]      fft_d1,
    output logic [2*DW-1:0]      fft_d2,
    output logic [2*DW-1:0]      fft_d3,
    output logic [2*DW-1:0]      fft_d4,
    output logic [2*DW-1:0]      fft_d5,
    output logic [2*DW-1:0]      fft_d6,
    output logic [2*DW-1:0]      fft_d7,
    output logic [2*DW-1:0]      fft_d8,
    output logic [2*DW-1:0]      fft_d9,
    output logic [2*DW-1:0]      fft_d10,
    output logic [2*DW-1:0]      fft_d11,
    output logic [2*DW-1:0]      fft_d12,
    output logic [2*DW-1:0]      fft_d13,
    output logic [2*DW-1:0]      fft_d14,
    output logic [2*DW-1:0]      fft_d15,
    output logic                 frame_err
);

    localparam int unsigned IW = $clog2(NBIN);
    localparam int unsigned PW = 2 * DW;
    localparam logic [IW-1:0] LastIdx = IW'(NBIN - 1);

    // Bin counter and resync detection
    logic [IW-1:0] idx_q;
    logic [IW-1:0] bin;
    logic          resync;
    logic          frame_err_q;

    always_comb begin
        bin    = in_first ? '0 : idx_q;
        resync = in_valid & in_first & (idx_q != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= resync;
            if (in_valid) begin
                idx_q <= bin + IW'(1);
            end
        end
    end

    // P1: squares, sign-extended first so the multiply is full 32-bit signed
    logic signed [PW-1:0] re_ext;
    logic signed [PW-1:0] im_ext;
    logic signed [PW-1:0] p1_re_q;
    logic signed [PW-1:0] p1_im_q;
    logic [IW-1:0]        p1_idx_q;
    logic                 p1_valid_q;
    logic                 p1_last_q;

    always_comb begin
        re_ext = signed'({{DW{in_re[DW-1]}}, in_re});
        im_ext = signed'({{DW{in_im[DW-1]}}, in_im});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p1_re_q    <= '0;
            p1_im_q    <= '0;
            p1_idx_q   <= '0;
            p1_valid_q <= 1'b0;
            p1_last_q  <= 1'b0;
        end else begin
            p1_re_q    <= re_ext * re_ext;
            p1_im_q    <= im_ext * im_ext;
            p1_idx_q   <= bin;
            p1_valid_q <= in_valid;
            p1_last_q  <= in_valid & (bin == LastIdx);
        end
    end

    // Adder operands, optionally retimed through P1a
    logic signed [PW-1:0] m_re;
    logic signed [PW-1:0] m_im;
    logic [IW-1:0]        m_idx;
    logic                 m_valid;
    logic                 m_last;

`ifdef FFT_PWR_PIPE_EN
    logic signed [PW-1:0] p1a_re_q;
    logic signed [PW-1:0] p1a_im_q;
    logic [IW-1:0]        p1a_idx_q;
    logic                 p1a_valid_q;
    logic                 p1a_last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            p1a_re_q    <= '0;
            p1a_im_q    <= '0;
            p1a_idx_q   <= '0;
            p1a_valid_q <= 1'b0;
            p1a_last_q  <= 1'b0;
        end else begin
            p1a_re_q    <= p1_re_q;
            p1a_im_q    <= p1_im_q;
            p1a_idx_q   <= p1_idx_q;
            p1a_valid_q <= p1_valid_q;
            p1a_last_q  <= p1_last_q;
        end
    end

    assign m_re    = p1a_re_q;
    assign m_im    = p1a_im_q;
    assign m_idx   = p1a_idx_q;
    assign m_valid = p1a_valid_q;
    assign m_last  = p1a_last_q;
`else
    assign m_re    = p1_re_q;
    assign m_im    = p1_im_q;
    assign m_idx   = p1_idx_q;
    assign m_valid = p1_valid_q;
    assign m_last  = p1_last_q;
`endif

    // P2: both squares are non-negative, so the unsigned sum tops out at 2^31
    logic [PW-1:0] sum_q;
    logic [IW-1:0] p2_idx_q;
    logic          p2_valid_q;
    logic          p2_last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q      <= '0;
            p2_idx_q   <= '0;
            p2_valid_q <= 1'b0;
            p2_last_q  <= 1'b0;
        end else begin
            sum_q      <= $unsigned(m_re) + $unsigned(m_im);
            p2_idx_q   <= m_idx;
            p2_valid_q <= m_valid;
            p2_last_q  <= m_last;
        end
    end

    // Work buffer and shadow output registers; the last bin bypasses work
    logic [PW-1:0] work_q [NBIN];
    logic [PW-1:0] dout_q [NBIN];
    logic          fft_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NBIN; k++) begin
                work_q[k] <= '0;
                dout_q[k] <= '0;
            end
            fft_valid_q <= 1'b0;
        end else begin
            fft_valid_q <= p2_valid_q & p2_last_q;
            if (p2_valid_q) begin
                work_q[p2_idx_q] <= sum_q;
            end
            if (p2_valid_q & p2_last_q) begin
                for (int unsigned k = 0; k < NBIN - 1; k++) begin
                    dout_q[k] <= work_q[k];
                end
                dout_q[NBIN-1] <= sum_q;
            end
        end
    end

    assign fft_valid = fft_valid_q;
    assign frame_err = frame_err_q;
    assign fft_d0    = dout_q[0];
    assign fft_d1    = dout_q[1];
    assign fft_d2    = dout_q[2];
    assign fft_d3    = dout_q[3];
    assign fft_d4    = dout_q[4];
    assign fft_d5    = dout_q[5];
    assign fft_d6    = dout_q[6];
    assign fft_d7    = dout_q[7];
    assign fft_d8    = dout_q[8];
    assign fft_d9    = dout_q[9];
    assign fft_d10   = dout_q[10];
    assign fft_d11   = dout_q[11];
    assign fft_d12   = dout_q[12];
    assign fft_d13   = dout_q[13];
    assign fft_d14   = dout_q[14];
    assign fft_d15   = dout_q[15];

endmodule

// File: doc/fft_power_collector.md
# fft_power_collector

Upstream feeder for the spectrum analyzer. Accepts one complex FFT bin per cycle in bin order 0..15 and computes each bin's power as re² + im². After all 16 bins of a frame are in, it presents the 16 powers in parallel on `fft_d0..fft_d15` with a one-cycle `fft_valid` pulse, the exact form the analyzer's comparator tree consumes. A shadow buffer keeps the outputs stable while the next frame is collected.

## Interface
Parameters:
- `NBIN`, 16: bins per frame. The block is only specified for 16.
- `DW`, 16: width of the signed real and imaginary inputs.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  bin present on `in_re`/`in_im` this cycle.
- `in_first`  in  1  qualifies `in_valid`; this bin is bin 0 of a new frame.
- `in_re`  in  16  signed two's-complement real part.
- `in_im`  in  16  signed two's-complement imaginary part.
- `fft_valid`  out  1  one-cycle pulse; `fft_d0..15` hold a complete new frame.
- `fft_d0` .. `fft_d15`  out  32 each  unsigned power of bin k.
- `frame_err`  out  1  one-cycle pulse; a partial frame was discarded.

## Operation
- **Bin counter `idx` (4 bits)**
  - Advances only on `in_valid`.
  - `in_valid & in_first` forces the bin to index 0; the next bin is 1.
  - `in_valid` with `idx=15` wraps to 0.
  - Gaps (`in_valid`=0) are allowed at any point and hold `idx`.
- **Power arithmetic**
  - p = re·re + im·im. Each product is computed as signed 16×16 into a 32-bit result.
  - The sum is unsigned 32-bit. Its maximum is 2³¹ (re = im = −32768), so it never overflows and is never saturated.
- **Pipeline**
  - P1 registers both products plus `idx`, a valid bit, and a last flag (`idx==15`).
  - P2 adds the products and writes the sum into work register `work[idx]`.
- **Frame completion**
  - On the P2 write carrying the last flag, all 16 `fft_dk` load together from `work[0..14]` and the current sum (bin 15 bypasses `work`).
  - `fft_valid` is registered high for exactly that following cycle.
- **Output hold**: outputs stay unchanged until the next complete frame loads.
- **Resync**
  - `in_valid & in_first` while `idx≠0` discards the partial frame.
  - `frame_err` pulses one cycle later.
  - The new frame proceeds normally, and no `fft_valid` is produced for the discarded frame.
- **Idle state**: none beyond `idx==0` with an empty pipeline; there is no other FSM.

## Timing
- **Reset values**
  - `fft_valid`=0, `frame_err`=0, all `fft_dk`=0.
  - `idx`=0, pipeline valids=0, `work` cleared.
- **Latency**
  - Bin 15 is sampled at edge E.
  - `fft_valid`=1 and the new `fft_dk` are visible in the cycle after edge E+2 (2 cycles).
- **Throughput**
  - Back-to-back frames are accepted with no bubble.
  - The minimum `fft_valid` spacing is 16 cycles, which exceeds the analyzer's 4-cycle occupancy.
- **Simultaneous events**
  - Bin 0 of frame N+1 may be sampled in the same cycle as frame N's output load. Both proceed, because `work` and `fft_dk` are separate registers.
- **Reset mid-frame**
  - Flushes the pipeline; no `fft_valid` is produced for the partial frame.
  - `fft_dk` return to 0.
- **Flow control**: there is no backpressure; upstream must not depend on a ready signal.

## Configuration
- **Macro `FFT_PWR_PIPE_EN`**
  - **Defined**: an extra register stage sits between the multipliers and the adder (P1a), for timing closure. Latency becomes 3 cycles; `frame_err` and the resync rules are unchanged.
  - **Undefined**: latency is 2 cycles as above.

## Test plan
- **Single frame**
  - Stimulus: reset, then 16 consecutive bins with re=k, im=−k (k = 0..15), `in_first` on bin 0.
  - Response: `fft_dk` = 2k²; `fft_valid` high one cycle, 2 cycles (3 with macro) after bin 15.
- **Extremes**
  - Stimulus: bin 7 with re = im = −32768, all other bins 0.
  - Response: `fft_d7` = 32'h8000_0000, no wrap.
- **Gaps and back-to-back**
  - Stimulus: frame A with random `in_valid` gaps, then frame B with no gap.
  - Response: two `fft_valid` pulses; A's values hold until B loads; B's bin 0 does not corrupt A.
- **Resync**
  - Stimulus: 9 bins, then `in_first` with a full frame of re=1, im=0.
  - Response: `frame_err` pulses once, a single `fft_valid` follows, and all `fft_dk` = 1.
- **Reset mid-frame**
  - Stimulus: assert `rst` after bin 10, then release.
  - Response: `fft_dk` = 0, no `fft_valid`; the next full frame is correct.
- **Analyzer integration**
  - Stimulus: chain into the analyzer; frame with peak power at bin 11.
  - Response: `done` pulses and `freq` = 11.
